// File: rtl/dbg_read_sched.sv
// rtl/dbg_read_sched.sv - debug test-port read scheduler shared by the LCD refresher and post-sort checker
module dbg_read_sched #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int CHK_BASE = 0,
  parameter int CHK_LEN  = 10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              lcd_req,
  input  logic              lcd_sel,
  input  logic [ADDR_W-1:0] lcd_addr,
  output logic              lcd_gnt,
  output logic              lcd_rvalid,
  output logic [DATA_W-1:0] lcd_rdata,
  input  logic              sort_over,
  output logic              chk_busy,
  output logic              chk_done,
  output logic              chk_ok,
  output logic [ADDR_W-1:0] chk_err_idx,
  output logic [ADDR_W-1:0] t_reg_addr,
  output logic [ADDR_W-1:0] t_ram_addr,
  input  logic [DATA_W-1:0] t_reg_data,
  input  logic [DATA_W-1:0] t_ram_data
);

  localparam logic OWN_LCD = 1'b0;
  localparam logic OWN_CHK = 1'b1;
  localparam logic [ADDR_W-1:0] CHK_FIRST = ADDR_W'(CHK_BASE);
  // One extra bit so a scan ending at the top address does not wrap to zero.
  localparam logic [ADDR_W:0]   CHK_END   = (ADDR_W+1)'(CHK_BASE + CHK_LEN);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_CMP, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              so_prev_q;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              have_prev_q, have_prev_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              ok_q, ok_d;
  logic [ADDR_W-1:0] err_idx_q, err_idx_d;
  logic [ADDR_W-1:0] t_reg_addr_q, t_reg_addr_d;
  logic [ADDR_W-1:0] t_ram_addr_q, t_ram_addr_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_owner_q, s1_owner_d;
  logic              s1_sel_q, s1_sel_d;
  logic              s2_valid_q, s2_valid_d;
  logic              s2_owner_q, s2_owner_d;
  logic [DATA_W-1:0] s2_data_q, s2_data_d;

  logic              so_rise, so_fall, busy, abort;
  logic              chk_req, chk_gnt, lcd_gnt_c, chk_ret;
  logic [ADDR_W:0]   idx_nxt;

  always_comb begin
    so_rise   = sort_over && !so_prev_q;
    so_fall   = !sort_over && so_prev_q;
    busy      = state_q inside {S_REQ, S_WAIT, S_CMP};
    abort     = busy && so_fall;
    chk_req   = resetn && (state_q == S_REQ) && !abort;
    lcd_gnt_c = resetn && lcd_req && (!chk_req || last_q == OWN_CHK);
    chk_gnt   = chk_req && (!lcd_req || last_q == OWN_LCD);
    chk_ret   = s2_valid_q && (s2_owner_q == OWN_CHK);
    idx_nxt   = {1'b0, idx_q} + (ADDR_W+1)'(1);
  end

  // Read pipeline: issue -> capture -> return, one issue per cycle.
  always_comb begin
    s1_valid_d   = lcd_gnt_c || chk_gnt;
    s1_owner_d   = chk_gnt ? OWN_CHK : OWN_LCD;
    s1_sel_d     = chk_gnt ? 1'b1 : lcd_sel;
    t_reg_addr_d = t_reg_addr_q;
    t_ram_addr_d = t_ram_addr_q;
    if (chk_gnt) begin
      t_ram_addr_d = idx_q;
    end else if (lcd_gnt_c) begin
      if (lcd_sel) t_ram_addr_d = lcd_addr;
      else         t_reg_addr_d = lcd_addr;
    end
    // An aborted scan's read still in capture is dropped here.
    s2_valid_d = s1_valid_q && !(abort && s1_owner_q == OWN_CHK);
    s2_owner_d = s1_owner_q;
    s2_data_d  = s2_data_q;
    if (s1_valid_q) s2_data_d = s1_sel_q ? t_ram_data : t_reg_data;
    last_d = last_q;
    if (chk_gnt)        last_d = OWN_CHK;
    else if (lcd_gnt_c) last_d = OWN_LCD;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    have_prev_d = have_prev_q;
    prev_d      = prev_q;
    data_d      = data_q;
    done_d      = done_q;
    ok_d        = ok_q;
    err_idx_d   = err_idx_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (so_rise) begin
          done_d      = 1'b0;
          ok_d        = 1'b0;
          err_idx_d   = '0;
          idx_d       = CHK_FIRST;
          have_prev_d = 1'b0;
          state_d     = S_REQ;
          if (CHK_LEN == 0) begin
            done_d  = 1'b1;
            ok_d    = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_REQ: begin
        if (chk_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (chk_ret) begin
          data_d  = s2_data_q;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        if (have_prev_q && ($signed(data_q) < $signed(prev_q))) begin
          ok_d      = 1'b0;
          err_idx_d = idx_q;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          prev_d      = data_q;
          have_prev_d = 1'b1;
          idx_d       = idx_nxt[ADDR_W-1:0];
          if (idx_nxt == CHK_END) begin
            ok_d      = 1'b1;
            err_idx_d = '0;
            done_d    = 1'b1;
            state_d   = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      ok_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      last_q       <= OWN_CHK;
      so_prev_q    <= 1'b0;
      idx_q        <= '0;
      have_prev_q  <= 1'b0;
      prev_q       <= '0;
      data_q       <= '0;
      done_q       <= 1'b0;
      ok_q         <= 1'b0;
      err_idx_q    <= '0;
      t_reg_addr_q <= '0;
      t_ram_addr_q <= '0;
      s1_valid_q   <= 1'b0;
      s1_owner_q   <= OWN_LCD;
      s1_sel_q     <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_owner_q   <= OWN_LCD;
      s2_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      so_prev_q    <= sort_over;
      idx_q        <= idx_d;
      have_prev_q  <= have_prev_d;
      prev_q       <= prev_d;
      data_q       <= data_d;
      done_q       <= done_d;
      ok_q         <= ok_d;
      err_idx_q    <= err_idx_d;
      t_reg_addr_q <= t_reg_addr_d;
      t_ram_addr_q <= t_ram_addr_d;
      s1_valid_q   <= s1_valid_d;
      s1_owner_q   <= s1_owner_d;
      s1_sel_q     <= s1_sel_d;
      s2_valid_q   <= s2_valid_d;
      s2_owner_q   <= s2_owner_d;
      s2_data_q    <= s2_data_d;
    end
  end

  assign lcd_gnt     = lcd_gnt_c;
  assign lcd_rvalid  = s2_valid_q && (s2_owner_q == OWN_LCD);
  assign lcd_rdata   = s2_data_q;
  assign chk_busy    = busy;
  assign chk_done    = done_q;
  assign chk_ok      = ok_q;
  assign chk_err_idx = err_idx_q;
  assign t_reg_addr  = t_reg_addr_q;
  assign t_ram_addr  = t_ram_addr_q;

endmodule

// File: tb/tb_dbg_read_sched.sv
// tb/tb_dbg_read_sched.sv - self-checking bench for dbg_read_sched
module tb_dbg_read_sched;
  localparam int ADDR_W = 5, DATA_W = 32, CHK_BASE = 0, CHK_LEN = 10;

  logic              clk = 1'b0, resetn = 1'b0;
  logic              lcd_req = 1'b0, lcd_sel = 1'b0;
  logic [ADDR_W-1:0] lcd_addr = '0;
  logic              lcd_gnt, lcd_rvalid;
  logic [DATA_W-1:0] lcd_rdata;
  logic              sort_over = 1'b0;
  logic              chk_busy, chk_done, chk_ok;
  logic [ADDR_W-1:0] chk_err_idx, t_reg_addr, t_ram_addr;
  logic [DATA_W-1:0] t_reg_data, t_ram_data;

  logic [DATA_W-1:0] regs [32];
  logic [DATA_W-1:0] ram  [32];
  logic [DATA_W-1:0] exp_q [$];

  logic              s_gnt, s_rvalid, s_busy, s_done, s_ok;
  logic [DATA_W-1:0] s_rdata;
  logic [ADDR_W-1:0] s_err, s_treg, s_tram;

  int errors = 0, checks = 0;

  int sorted_v [10] = '{-5, -1, 0, 2, 2, 7, 9, 10, 100, 32'h7FFF_FFFF};
  int unsort_v [10] = '{1, 2, 3, 8, 4, 5, 6, 7, 9, 10};

  assign t_reg_data = regs[t_reg_addr];
  assign t_ram_data = ram[t_ram_addr];

  always #5 clk = ~clk;

  dbg_read_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CHK_BASE(CHK_BASE), .CHK_LEN(CHK_LEN)) dut (
    .clk(clk), .resetn(resetn),
    .lcd_req(lcd_req), .lcd_sel(lcd_sel), .lcd_addr(lcd_addr),
    .lcd_gnt(lcd_gnt), .lcd_rvalid(lcd_rvalid), .lcd_rdata(lcd_rdata),
    .sort_over(sort_over), .chk_busy(chk_busy), .chk_done(chk_done),
    .chk_ok(chk_ok), .chk_err_idx(chk_err_idx),
    .t_reg_addr(t_reg_addr), .t_ram_addr(t_ram_addr),
    .t_reg_data(t_reg_data), .t_ram_data(t_ram_data)
  );

  // Samples one cycle at the falling edge, runs the LCD scoreboard, returns just after the next rising edge.
  task automatic step();
    logic [DATA_W-1:0] exp_d;
    @(negedge clk);
    s_gnt = lcd_gnt; s_rvalid = lcd_rvalid; s_rdata = lcd_rdata;
    s_busy = chk_busy; s_done = chk_done; s_ok = chk_ok; s_err = chk_err_idx;
    s_treg = t_reg_addr; s_tram = t_ram_addr;
    if (lcd_rvalid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_rvalid: got lcd_rvalid=1 rdata=%h, required no return", lcd_rdata);
      end else begin
        exp_d = exp_q.pop_front();
        if (lcd_rdata !== exp_d) begin
          errors++;
          $display("FAIL sb_lcd_rdata: got %h, required %h", lcd_rdata, exp_d);
        end
      end
    end
    if (lcd_req === 1'b1 && lcd_gnt === 1'b1)
      exp_q.push_back(lcd_sel ? ram[lcd_addr] : regs[lcd_addr]);
    @(posedge clk);
    #1;
  endtask

  task automatic run_scan(output int busy_n, output bit finished);
    busy_n = 0;
    finished = 1'b0;
    sort_over = 1'b1;
    step();
    for (int i = 0; i < 400; i++) begin
      step();
      if (s_done === 1'b1) begin
        finished = 1'b1;
        break;
      end
      if (s_busy === 1'b1) busy_n++;
    end
  endtask

  task automatic load_ram(input bit sorted);
    for (int i = 0; i < 10; i++) ram[i] = sorted ? sorted_v[i] : unsort_v[i];
  endtask

  task automatic test_reset();
    resetn = 1'b0; lcd_req = 1'b0; sort_over = 1'b0;
    step(); step();
    resetn = 1'b1;
    step();
    checks += 9;
    if (s_gnt !== 1'b0)    begin errors++; $display("FAIL reset_gnt: got %b, required 0", s_gnt); end
    if (s_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b, required 0", s_rvalid); end
    if (s_rdata !== '0)    begin errors++; $display("FAIL reset_rdata: got %h, required 0", s_rdata); end
    if (s_busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b, required 0", s_busy); end
    if (s_done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b, required 0", s_done); end
    if (s_ok !== 1'b0)     begin errors++; $display("FAIL reset_ok: got %b, required 0", s_ok); end
    if (s_err !== '0)      begin errors++; $display("FAIL reset_err_idx: got %0d, required 0", s_err); end
    if (s_treg !== '0)     begin errors++; $display("FAIL reset_t_reg_addr: got %0d, required 0", s_treg); end
    if (s_tram !== '0)     begin errors++; $display("FAIL reset_t_ram_addr: got %0d, required 0", s_tram); end
  endtask

  task automatic test_lcd_single();
    regs[3] = 32'h0000_00AB;
    lcd_req = 1'b1; lcd_sel = 1'b0; lcd_addr = 5'd3;
    step();
    checks++;
    if (s_gnt !== 1'b1) begin errors++; $display("FAIL single_gnt: got %b, required 1", s_gnt); end
    lcd_req = 1'b0;
    step();
    checks++;
    if (s_treg !== 5'd3) begin errors++; $display("FAIL single_t_reg_addr: got %0d, required 3", s_treg); end
    step();
    checks += 2;
    if (s_rvalid !== 1'b1) begin errors++; $display("FAIL single_rvalid: got %b, required 1", s_rvalid); end
    if (s_rdata !== 32'hAB) begin errors++; $display("FAIL single_rdata: got %h, required 000000ab", s_rdata); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      lcd_req = 1'b1; lcd_sel = 1'(i); lcd_addr = 5'($urandom);
      step();
      checks++;
      if (s_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b, required 1", i, s_gnt); end
    end
    lcd_req = 1'b0;
    step(); step(); step();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic check_scan(input string name, input bit exp_ok, input logic [ADDR_W-1:0] exp_err,
                            input int exp_busy, input int busy_n, input bit finished);
    checks += 4;
    if (finished !== 1'b1) begin errors++; $display("FAIL %s_timeout: got no chk_done, required chk_done", name); end
    if (s_ok !== exp_ok)   begin errors++; $display("FAIL %s_ok: got %b, required %b", name, s_ok, exp_ok); end
    if (s_err !== exp_err) begin errors++; $display("FAIL %s_err_idx: got %0d, required %0d", name, s_err, exp_err); end
    if (busy_n != exp_busy) begin errors++; $display("FAIL %s_busy_cycles: got %0d, required %0d", name, busy_n, exp_busy); end
  endtask

  task automatic test_sorted_pass();
    int busy_n; bit fin;
    load_ram(1'b1);
    run_scan(busy_n, fin);
    check_scan("sorted", 1'b1, 5'd0, 4 * CHK_LEN, busy_n, fin);
    sort_over = 1'b0;
    step();
  endtask

  task automatic test_unsorted();
    int busy_n; bit fin;
    load_ram(1'b0);
    run_scan(busy_n, fin);
    check_scan("unsorted", 1'b0, 5'd4, 4 * 5, busy_n, fin);
    sort_over = 1'b0;
    step();
  endtask

  task automatic test_contention();
    int busy_n = 0, denials = 0, double_denials = 0;
    bit fin = 1'b0, prev_denied = 1'b0;
    load_ram(1'b1);
    lcd_req = 1'b1; lcd_sel = 1'($urandom); lcd_addr = 5'($urandom);
    sort_over = 1'b1;
    step();
    if (s_gnt) begin lcd_sel = 1'($urandom); lcd_addr = 5'($urandom); end
    for (int i = 0; i < 400; i++) begin
      step();
      if (s_done === 1'b1) begin fin = 1'b1; break; end
      if (s_busy === 1'b1) begin
        busy_n++;
        if (!s_gnt) begin
          denials++;
          if (prev_denied) double_denials++;
        end
      end
      prev_denied = s_busy && !s_gnt;
      if (s_gnt) begin lcd_sel = 1'($urandom); lcd_addr = 5'($urandom); end
    end
    check_scan("contend", 1'b1, 5'd0, 4 * CHK_LEN, busy_n, fin);
    checks += 2;
    if (denials != CHK_LEN) begin errors++; $display("FAIL contend_denials: got %0d, required %0d", denials, CHK_LEN); end
    if (double_denials != 0) begin errors++; $display("FAIL contend_alternate: got %0d back-to-back denials, required 0", double_denials); end
    lcd_req = 1'b0; sort_over = 1'b0;
    step(); step(); step();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL contend_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_abort_restart();
    int busy_n; bit fin;
    load_ram(1'b1);
    sort_over = 1'b1;
    step(); step(); step(); step();
    sort_over = 1'b0;
    step();
    checks++;
    if (s_busy !== 1'b1) begin errors++; $display("FAIL abort_was_busy: got %b, required 1", s_busy); end
    step();
    checks += 3;
    if (s_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, required 0", s_busy); end
    if (s_done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b, required 0", s_done); end
    if (s_ok !== 1'b0)   begin errors++; $display("FAIL abort_ok: got %b, required 0", s_ok); end
    load_ram(1'b0);
    run_scan(busy_n, fin);
    check_scan("restart", 1'b0, 5'd4, 4 * 5, busy_n, fin);
    sort_over = 1'b0;
    step();
  endtask

  task automatic test_mid_read_reset();
    lcd_req = 1'b1; lcd_sel = 1'b0; lcd_addr = 5'd7;
    step();
    checks++;
    if (s_gnt !== 1'b1) begin errors++; $display("FAIL midrst_gnt: got %b, required 1", s_gnt); end
    lcd_req = 1'b0; resetn = 1'b0;
    step();
    resetn = 1'b1;
    exp_q.delete();
    step();
    checks += 9;
    if (s_gnt !== 1'b0)    begin errors++; $display("FAIL midrst_gnt_after: got %b, required 0", s_gnt); end
    if (s_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid: got %b, required 0", s_rvalid); end
    if (s_rdata !== '0)    begin errors++; $display("FAIL midrst_rdata: got %h, required 0", s_rdata); end
    if (s_busy !== 1'b0)   begin errors++; $display("FAIL midrst_busy: got %b, required 0", s_busy); end
    if (s_done !== 1'b0)   begin errors++; $display("FAIL midrst_done: got %b, required 0", s_done); end
    if (s_ok !== 1'b0)     begin errors++; $display("FAIL midrst_ok: got %b, required 0", s_ok); end
    if (s_err !== '0)      begin errors++; $display("FAIL midrst_err_idx: got %0d, required 0", s_err); end
    if (s_treg !== '0)     begin errors++; $display("FAIL midrst_t_reg_addr: got %0d, required 0", s_treg); end
    if (s_tram !== '0)     begin errors++; $display("FAIL midrst_t_ram_addr: got %0d, required 0", s_tram); end
    step(); step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      regs[i] = $urandom;
      ram[i]  = $urandom;
    end
    @(posedge clk);
    #1;
    test_reset();
    test_lcd_single();
    test_back_to_back();
    test_sorted_pass();
    test_unsorted();
    test_contention();
    test_abort_restart();
    test_mid_read_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run, required finish before time limit");
    $fatal(1);
  end

endmodule

// File: doc/dbg_read_sched.md
# dbg_read_sched

Read scheduler for the CPU's debug test ports (`t_reg_addr`/`t_reg_data`, `t_ram_addr`/`t_ram_data`). It sits between the single-cycle sorting CPU and its two debug consumers:
- the LCD display refresher, which sweeps register and RAM words for display;
- a built-in post-sort checker, which scans data RAM after `sort_over` rises and reports whether the result is in non-decreasing signed order.

The block arbitrates the shared test read path between the two, pipelines each read and routes the returned data to the requester that issued it.

## Interface
- `ADDR_W`, 5, width of test-port addresses
- `DATA_W`, 32, width of test-port data
- `CHK_BASE`, 0, first RAM word address scanned by the checker
- `CHK_LEN`, 10, number of RAM words checked; must satisfy CHK_BASE+CHK_LEN <= 2^ADDR_W

Ports:
- `clk`  in  1  clock
- `resetn`  in  1  reset, synchronous, active-low
- `lcd_req`  in  1  LCD requests one read this cycle
- `lcd_sel`  in  1  0 = register file, 1 = data RAM
- `lcd_addr`  in  ADDR_W  LCD read address
- `lcd_gnt`  out  1  combinational; LCD request accepted this cycle
- `lcd_rvalid`  out  1  `lcd_rdata` valid (one-cycle pulse)
- `lcd_rdata`  out  DATA_W  returned data for LCD
- `sort_over`  in  1  CPU sort-complete level
- `chk_busy`  out  1  checker scan in progress
- `chk_done`  out  1  checker finished, result valid; held
- `chk_ok`  out  1  1 = scanned words are non-decreasing (signed); valid when `chk_done`
- `chk_err_idx`  out  ADDR_W  address of the first offending word; 0 if ok
- `t_reg_addr`  out  ADDR_W  registered address to CPU register test port
- `t_ram_addr`  out  ADDR_W  registered address to CPU RAM test port
- `t_reg_data`  in  DATA_W  combinational register read data from CPU
- `t_ram_data`  in  DATA_W  combinational RAM read data from CPU

## Operation
- **Two-stage read pipeline.**
  - Issue (cycle T): the granted request's address is loaded into `t_reg_addr` or `t_ram_addr` per `sel`. The other address output holds its value.
  - Capture (T+1): `t_*_data` selected by the stage `sel` is registered together with the owner tag.
  - Return (T+2): `lcd_rvalid` pulses, or the checker consumes the data.
- One issue per cycle. Back-to-back issues are allowed. Results return in issue order.
- **Arbitration.**
  - A single `last` bit records the most recent grant owner. Reset value: checker.
  - Only one requester active: it is granted.
  - Both active: the one ≠ `last` is granted.
  - `lcd_gnt` = `lcd_req` && (no checker request || `last` == checker).
  - An ungranted LCD request must be held by the LCD side. The block does not queue it.
- **Checker FSM**, states IDLE, REQ, WAIT, CMP, DONE:
  - IDLE: on a `sort_over` rising edge (registered previous value), clear `chk_done`/`chk_ok`/`chk_err_idx`, set idx=CHK_BASE, have_prev=0, go to REQ.
  - REQ: request a RAM read of idx. Stay until granted, then go to WAIT.
  - WAIT: wait for the tagged return, then go to CMP.
  - CMP:
    - If have_prev && $signed(data) < $signed(prev): set chk_ok=0, chk_err_idx=idx, go to DONE.
    - Else: prev=data, have_prev=1, idx+1.
    - If idx+1 == CHK_BASE+CHK_LEN: set chk_ok=1, chk_err_idx=0, go to DONE. Otherwise go to REQ.
  - DONE: hold the results with `chk_done`=1. A new `sort_over` rising edge restarts the scan.
  - `chk_busy` = state ∈ {REQ, WAIT, CMP}.
- **Abort.** `sort_over` falling while busy → return to IDLE, `chk_done`=0, `chk_ok`=0. Any in-flight checker read is discarded on return.
- **Edge cases.**
  - CHK_LEN=1: one read, then chk_ok=1.
  - CHK_LEN=0: IDLE → DONE directly with chk_ok=1 and no read issued.
- The index compare uses ADDR_W+1 bits so the last word at address 2^ADDR_W−1 terminates without wrap-around.

## Timing
- **Reset:** all outputs are 0. Pipeline valid bits are cleared. FSM = IDLE. `last` = checker. Previous-`sort_over` register = 0. Reset mid-scan or mid-read drops everything; no `lcd_rvalid` is produced for pre-reset grants.
- **LCD latency:** grant at T → `lcd_rvalid` at T+2, with data = CPU port value during T+1.
- **Checker throughput:** at least 4 cycles per word (REQ, issue/WAIT ×2, CMP) when uncontested.
- A `sort_over` rise in the same cycle as `resetn`=0 is ignored.

## Test plan
- **LCD single read.** Reset; `lcd_req`=1, `sel`=0, `addr`=3 for one cycle with register 3 = 0x0000_00AB → `lcd_gnt`=1 at T, `t_reg_addr`=3 at T+1, `lcd_rvalid`=1 with `lcd_rdata`=0xAB at T+2.
- **Sorted RAM pass.** RAM[0..9] = -5,-1,0,2,2,7,9,10,100,0x7FFF_FFFF; pulse `sort_over` → `chk_done`=1, `chk_ok`=1, `chk_err_idx`=0. Exactly 10 RAM reads issued.
- **Unsorted RAM detection.** RAM[0..9] = 1,2,3,8,4,… → `chk_ok`=0, `chk_err_idx`=4. Scan stops after the 5th read.
- **Contention fairness.** LCD requests continuously during a checker scan → grants alternate LCD/checker. Every `lcd_rvalid` carries data for its own address. Checker result matches the uncontested run.
- **Abort and restart.** Drop `sort_over` mid-scan → `chk_busy`=0, `chk_done`=0. A later rise rescans from CHK_BASE with the correct result.
- **Mid-read reset.** Assert `resetn`=0 one cycle after an LCD grant → no `lcd_rvalid`. All outputs are 0 the cycle after reset.
